// File: rtl/conf_disp_accumulate.sv
// Sliding-window accumulator of confidence and confidence*disparity over the
// trailing win_size pixels of a line, saturated to the divider input widths.
module conf_disp_accumulate #(
  parameter int disp_bits = 5,
  parameter int conf_bits = 5,
  parameter int win_size  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [disp_bits-1:0]   in_disp,
  input  logic [conf_bits-1:0]   in_conf,
  input  logic                   in_sol,
  input  logic                   in_valid,
  output logic [7:0]             out_conf,
  output logic [8+disp_bits-1:0] out_conf_disp,
  output logic                   out_valid
);

  localparam int win_log     = $clog2(win_size);
  localparam int prod_bits   = conf_bits + disp_bits;
  localparam int sum_c_bits  = conf_bits + win_log;
  localparam int sum_cd_bits = prod_bits + win_log;
  localparam int out_cd_bits = 8 + disp_bits;
  localparam int fill_bits   = win_log + 1;
  localparam int unsigned conf_max = 255;
  localparam int unsigned cd_max   = (2 ** out_cd_bits) - 1;

  logic [conf_bits-1:0]   hist_c [win_size];
  logic [prod_bits-1:0]   hist_p [win_size];
  logic [fill_bits-1:0]   fill;
  logic [conf_bits-1:0]   conf_r, old_c_r;
  logic [prod_bits-1:0]   prod_r, old_p_r;
  logic                   sol_r, v1, v2;
  logic [sum_c_bits-1:0]  sum_c;
  logic [sum_cd_bits-1:0] sum_cd;
  logic                   drop_oldest;

  // The oldest entry only leaves the window once the window is full; a line
  // start discards everything, so stale history is never subtracted.
  assign drop_oldest = (fill == fill_bits'(win_size)) && !in_sol;

  // History needs no reset: the fill count masks whatever it holds.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = win_size - 1; i > 0; i--) begin
        hist_c[i] <= hist_c[i-1];
        hist_p[i] <= hist_p[i-1];
      end
      hist_c[0] <= in_conf;
      hist_p[0] <= prod_bits'(in_conf) * prod_bits'(in_disp);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill    <= '0;
      conf_r  <= '0;
      prod_r  <= '0;
      old_c_r <= '0;
      old_p_r <= '0;
      sol_r   <= 1'b0;
      v1      <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        conf_r  <= in_conf;
        prod_r  <= prod_bits'(in_conf) * prod_bits'(in_disp);
        sol_r   <= in_sol;
        old_c_r <= drop_oldest ? hist_c[win_size-1] : '0;
        old_p_r <= drop_oldest ? hist_p[win_size-1] : '0;
        if (in_sol)
          fill <= fill_bits'(1);
        else if (fill != fill_bits'(win_size))
          fill <= fill + fill_bits'(1);
      end
    end
  end

  // Running sums restart from zero on a line-start beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_c  <= '0;
      sum_cd <= '0;
      v2     <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum_c  <= (sol_r ? '0 : sum_c) + sum_c_bits'(conf_r) - sum_c_bits'(old_c_r);
        sum_cd <= (sol_r ? '0 : sum_cd) + sum_cd_bits'(prod_r) - sum_cd_bits'(old_p_r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_conf      <= '0;
      out_conf_disp <= '0;
      out_valid     <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_conf      <= (32'(sum_c) > conf_max) ? 8'hFF : 8'(sum_c);
        out_conf_disp <= (32'(sum_cd) > cd_max) ? {out_cd_bits{1'b1}}
                                                 : out_cd_bits'(sum_cd);
      end
    end
  end

endmodule

// File: tb/tb_conf_disp_accumulate.sv
// Directed bench for conf_disp_accumulate: default instance plus a
// conf_bits=6 instance for the saturation scenario.
module tb_conf_disp_accumulate;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  in_disp, in_conf;
  logic        in_sol, in_valid;
  logic [7:0]  out_conf;
  logic [12:0] out_conf_disp;
  logic        out_valid;

  logic [4:0]  s_disp;
  logic [5:0]  s_conf;
  logic        s_sol, s_valid;
  logic [7:0]  s_out_conf;
  logic [12:0] s_out_conf_disp;
  logic        s_out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conf_disp_accumulate dut (
    .clk(clk), .reset(reset), .in_disp(in_disp), .in_conf(in_conf),
    .in_sol(in_sol), .in_valid(in_valid), .out_conf(out_conf),
    .out_conf_disp(out_conf_disp), .out_valid(out_valid)
  );

  conf_disp_accumulate #(.disp_bits(5), .conf_bits(6), .win_size(8)) dut_sat (
    .clk(clk), .reset(reset), .in_disp(s_disp), .in_conf(s_conf),
    .in_sol(s_sol), .in_valid(s_valid), .out_conf(s_out_conf),
    .out_conf_disp(s_out_conf_disp), .out_valid(s_out_valid)
  );

  task automatic drive(input logic v, input logic sol, input logic [4:0] c, input logic [4:0] d);
    in_valid = v;
    in_sol   = sol;
    in_conf  = c;
    in_disp  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 5'd0);
    s_valid = 1'b0; s_sol = 1'b0; s_conf = '0; s_disp = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_valid cycle %0d: got %0b expected 0", t, out_valid);
      end
      total++;
      if (out_conf !== 8'd0) begin
        bad++; $display("[TB] FAIL reset_conf cycle %0d: got %0d expected 0", t, out_conf);
      end
      total++;
      if (out_conf_disp !== 13'd0) begin
        bad++; $display("[TB] FAIL reset_conf_disp cycle %0d: got %0d expected 0", t, out_conf_disp);
      end
    end
  endtask

  // 12 back-to-back beats conf=4 disp=10, first one starts the line.
  task automatic test_constant_fill;
    int n;
    for (int t = 0; t < 14; t++) begin
      if (t < 12) drive(1'b1, t == 0, 5'd4, 5'd10);
      else        drive(1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      total++;
      if (out_valid !== (t >= 2)) begin
        bad++; $display("[TB] FAIL fill_valid cycle %0d: got %0b expected %0b", t, out_valid, t >= 2);
      end
      if (t >= 2) begin
        n = (t - 1 < 8) ? t - 1 : 8;
        total++;
        if (out_conf !== 8'(4 * n)) begin
          bad++; $display("[TB] FAIL fill_conf beat %0d: got %0d expected %0d", t - 2, out_conf, 4 * n);
        end
        total++;
        if (out_conf_disp !== 13'(40 * n)) begin
          bad++; $display("[TB] FAIL fill_conf_disp beat %0d: got %0d expected %0d", t - 2, out_conf_disp, 40 * n);
        end
      end
    end
  endtask

  task automatic test_mid_line_start;
    for (int t = 0; t < 4; t++) begin
      if (t < 2) drive(1'b1, t == 0, 5'd1, 5'd3);
      else       drive(1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      if (t >= 2) begin
        total++;
        if (out_valid !== 1'b1) begin
          bad++; $display("[TB] FAIL sol_valid beat %0d: got %0b expected 1", t - 2, out_valid);
        end
        total++;
        if (out_conf !== 8'(t - 1)) begin
          bad++; $display("[TB] FAIL sol_conf beat %0d: got %0d expected %0d", t - 2, out_conf, t - 1);
        end
        total++;
        if (out_conf_disp !== 13'(3 * (t - 1))) begin
          bad++; $display("[TB] FAIL sol_conf_disp beat %0d: got %0d expected %0d", t - 2, out_conf_disp, 3 * (t - 1));
        end
      end
    end
  endtask

  // Same line as the constant-fill test, with valid pattern 1,0,0,1,0,1.
  task automatic test_bubbles;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic vhist [26];
    int in_cnt = 0;
    int out_cnt = 0;
    int n;
    int last_c = 2;
    int last_cd = 6;
    logic v;
    for (int t = 0; t < 26; t++) begin
      v = (t < 24) ? pat[t % 6] : 1'b0;
      vhist[t] = v;
      drive(v, v && (in_cnt == 0), 5'd4, 5'd10);
      if (v) in_cnt++;
      tick();
      total++;
      if (out_valid !== ((t >= 2) ? vhist[t-2] : 1'b0)) begin
        bad++; $display("[TB] FAIL bubble_valid cycle %0d: got %0b", t, out_valid);
      end
      if (t >= 2 && vhist[t-2]) begin
        out_cnt++;
        n = (out_cnt < 8) ? out_cnt : 8;
        last_c = 4 * n;
        last_cd = 40 * n;
      end
      total++;
      if (out_conf !== 8'(last_c)) begin
        bad++; $display("[TB] FAIL bubble_conf cycle %0d: got %0d expected %0d", t, out_conf, last_c);
      end
      total++;
      if (out_conf_disp !== 13'(last_cd)) begin
        bad++; $display("[TB] FAIL bubble_conf_disp cycle %0d: got %0d expected %0d", t, out_conf_disp, last_cd);
      end
    end
    total++;
    if (out_cnt != 12) begin
      bad++; $display("[TB] FAIL bubble_count: got %0d expected 12", out_cnt);
    end
  endtask

  task automatic test_saturation;
    int exp_c, exp_cd;
    for (int t = 0; t < 10; t++) begin
      s_valid = (t < 8);
      s_sol   = (t == 0);
      s_conf  = 6'd63;
      s_disp  = 5'd31;
      tick();
      if (t >= 2) begin
        exp_c  = (63 * (t - 1) > 255) ? 255 : 63 * (t - 1);
        exp_cd = (1953 * (t - 1) > 8191) ? 8191 : 1953 * (t - 1);
        total++;
        if (s_out_valid !== 1'b1) begin
          bad++; $display("[TB] FAIL sat_valid beat %0d: got %0b expected 1", t - 2, s_out_valid);
        end
        total++;
        if (s_out_conf !== 8'(exp_c)) begin
          bad++; $display("[TB] FAIL sat_conf beat %0d: got %0d expected %0d", t - 2, s_out_conf, exp_c);
        end
        total++;
        if (s_out_conf_disp !== 13'(exp_cd)) begin
          bad++; $display("[TB] FAIL sat_conf_disp beat %0d: got %0d expected %0d", t - 2, s_out_conf_disp, exp_cd);
        end
      end
    end
    s_valid = 1'b0;
    s_sol = 1'b0;
  endtask

  task automatic test_reset_mid_line;
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, t == 0, 5'd2, 5'd1);
      tick();
      if (t >= 2) begin
        total++;
        if (out_conf !== 8'(2 * (t - 1)) || out_valid !== 1'b1) begin
          bad++; $display("[TB] FAIL midrst_pre beat %0d: got %0d/%0b expected %0d/1", t - 2, out_conf, out_valid, 2 * (t - 1));
        end
      end
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_conf !== 8'd0 || out_conf_disp !== 13'd0) begin
      bad++; $display("[TB] FAIL midrst_cleared: got %0b/%0d/%0d expected 0/0/0", out_valid, out_conf, out_conf_disp);
    end
    for (int t = 0; t < 4; t++) begin
      if (t == 1) drive(1'b1, 1'b0, 5'd2, 5'd1);
      else        drive(1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      total++;
      if (out_valid !== (t == 3)) begin
        bad++; $display("[TB] FAIL midrst_valid cycle %0d: got %0b expected %0b", t, out_valid, t == 3);
      end
    end
    total++;
    if (out_conf !== 8'd2) begin
      bad++; $display("[TB] FAIL midrst_conf: got %0d expected 2", out_conf);
    end
    total++;
    if (out_conf_disp !== 13'd2) begin
      bad++; $display("[TB] FAIL midrst_conf_disp: got %0d expected 2", out_conf_disp);
    end
  endtask

  initial begin
    test_reset();
    test_constant_fill();
    test_mid_line_start();
    test_bubbles();
    test_saturation();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conf_disp_accumulate.md
# conf_disp_accumulate

Sliding-window confidence accumulator that produces the weighted-disparity sums for the downstream confidence/disparity divider. Per pixel it takes a disparity and its match confidence. It keeps running sums of confidence and of confidence×disparity over the last `win_size` pixels of the current line. It emits both sums per pixel, width-matched to the divider inputs (8 bits and 8+disp_bits bits).

## Interface
- `disp_bits`, 5, disparity width; `out_conf_disp` is 8+disp_bits wide.
- `conf_bits`, 5, per-pixel confidence width.
- `win_size`, 8, window length in pixels; power of two, 2..32.
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_disp`  in  disp_bits  per-pixel disparity.
- `in_conf`  in  conf_bits  per-pixel confidence.
- `in_sol`  in  1  start of line, qualified by `in_valid`.
- `in_valid`  in  1  input beat strobe; no backpressure.
- `out_conf`  out  8  saturated window sum of confidence.
- `out_conf_disp`  out  8+disp_bits  saturated window sum of conf×disp.
- `out_valid`  out  1  output beat strobe.

## Operation
- **Stage 1** (captures only when `in_valid`=1):
  - register `prod = in_conf*in_disp`, width conf_bits+disp_bits;
  - register `in_conf` and `in_sol`;
  - push {conf, prod} into a win_size-deep shift register and pop the oldest entry.
  - `v1 <= in_valid` every cycle.
- **Fill counter**, 0..win_size:
  - on a `in_sol` beat it loads 1;
  - otherwise it increments per beat and saturates at win_size.
- **Oldest-entry masking:** the popped oldest entry is treated as zero when the pre-update fill < win_size, or when the beat has `in_sol`.
- **Stage 2:** when `v1`=1, update the running sums:
  - `sum_c <= (sol ? 0 : sum_c) + conf − oldest_c`
  - `sum_cd <= (sol ? 0 : sum_cd) + prod − oldest_cd`
  - internal widths are conf_bits+log2(win_size) and conf_bits+disp_bits+log2(win_size); these never overflow.
- **Outputs:** registered from stage 2.
  - `out_conf = min(sum_c, 255)`.
  - `out_conf_disp = min(sum_cd, 2^(8+disp_bits)−1)`.
  - `out_valid` pulses one cycle per stage-2 update.
- **Line start:** the first pixel of a line yields sums equal to that pixel alone. Pixels 1..win_size−1 yield partial sums. There is no end-of-line drain, so the output count equals the input count.
- **Window alignment:** the window is trailing; each output aligns with the newest pixel in the window. Centring is the consumer's job.
- **Input before first `in_sol`:** beats without a prior `in_sol` after reset accumulate from fill=0, identical to a line start.
- **Bubbles:** gaps in `in_valid` freeze all state. Sums depend only on the sequence of valid beats, not on their spacing.
- **Reset:** clears the fill counter, sums, stage registers, and all outputs. Shift-register contents need not clear, because the fill mask hides them.

## Timing
- **Latency:** an input beat at edge N drives `out_valid`=1 with its sums after edge N+2.
- **Throughput:** one beat per cycle sustained.
- **Reset values:** `out_conf`=0, `out_conf_disp`=0, `out_valid`=0. The first possible `out_valid` is 2 cycles after the first valid beat following reset deassertion.
- **Output hold:** outputs hold their last value while `out_valid`=0.
- **`in_sol` in steady state:** takes effect on that same beat. Its output contains only the `in_sol` pixel; nothing from the prior line leaks in.
- **Reset mid-line:** in-flight beats are discarded and no `out_valid` is produced for them. The next beat starts a fresh window even without `in_sol`.
- **Back-to-back `in_sol` beats:** each output equals that single pixel.

## Test plan
1. **Reset, no stimulus.** Hold reset 3 cycles, release, drive no input. Required: all outputs 0 for 10 cycles.
2. **Constant fill (defaults).** `in_sol` then 12 beats back-to-back, disp=10, conf=4.
   - `out_conf` = 4, 8, …, 32, then 32 held.
   - `out_conf_disp` = 40, 80, …, 320, then 320 held.
   - each output 2 cycles after its input.
3. **Mid-stream line start.** After test 2 steady state, send an `in_sol` beat with conf=1, disp=3. Required: that output is 1/3; the next beat (conf=1, disp=3) gives 2/6.
4. **Bubble independence.** Repeat test 2 with `in_valid` pattern 1,0,0,1,0,1… Required: identical sum sequence, with each `out_valid` exactly 2 cycles after its input beat.
5. **Saturation.** Set conf_bits=6; send `in_sol` then 8 beats of conf=63, disp=31. Required:
   - `out_conf` = 63, 126, 189, 252, then 255 (saturated).
   - `out_conf_disp` = 1953, 3906, 5859, 7812, then 8191 (saturated).
6. **Reset mid-line.** Drive 5 beats conf=2, disp=1; assert reset one cycle with a beat in flight; then drive 1 beat conf=2, disp=1 with no `in_sol`. Required: no output for the flushed beat, then output 2/2.
